// File: rtl/instr_issue_buffer.sv
// rtl/instr_issue_buffer.sv - multi-lane in-order issue packet buffer (optional same-cycle bypass: INSTR_ISSUE_BUFFER_BYPASS_EN)
module instr_issue_buffer #(
  parameter int XLEN   = 32,
  parameter int REG_W  = 6,
  parameter int FLAG_W = 8,
  parameter int NAME_W = 8,
  parameter int ST_W   = 2,
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 8,
  localparam int PKT_W  = 2*XLEN + 4*REG_W + FLAG_W + NAME_W + ST_W,
  localparam int TAKE_W = $clog2(WIDTH+1),
  localparam int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       in_valid,
  input  logic [WIDTH*PKT_W-1:0] in_data,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_valid,
  output logic [WIDTH*PKT_W-1:0] out_data,
  input  logic [TAKE_W-1:0]      out_take,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] n_push;
  logic [CNT_W-1:0] n_push_acc;
  logic [CNT_W-1:0] n_pop;
  logic [CNT_W-1:0] n_skip;
  logic [CNT_W-1:0] avail;
  logic             run;
  logic             push_acc;
  logic             bypass;

  // Only the leading run of valid lanes counts; lanes after the first gap are ignored.
  always_comb begin
    n_push = '0;
    run    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      run = run & in_valid[i];
      if (run) n_push = n_push + CNT_W'(1);
    end
  end

  // Readiness depends on registered occupancy only, so out_take never reaches in_ready.
  assign in_ready   = !reset && !flush && ((DEPTH_C - count) >= WIDTH_C);
  assign push_acc   = in_ready && (n_push != '0);
  assign n_push_acc = push_acc ? n_push : '0;

`ifdef INSTR_ISSUE_BUFFER_BYPASS_EN
  assign bypass = in_ready && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  // Lanes the consumer can see this cycle: stored entries, or the incoming group when bypassing.
  assign avail  = bypass ? n_push_acc : count;
  // Lanes taken straight off the input are never written to storage.
  assign n_skip = bypass ? n_pop : '0;

  // Clamp the requested take to what is visible and to the lane count.
  always_comb begin
    n_pop = CNT_W'(out_take);
    if (n_pop > avail)   n_pop = avail;
    if (n_pop > WIDTH_C) n_pop = WIDTH_C;
  end

  // Present the oldest WIDTH entries; the bypass group overrides when the buffer is empty.
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_valid[i]                = count > CNT_W'(i);
      out_data[i*PKT_W +: PKT_W]  = mem[rd_ptr + PTR_W'(i)];
    end
`ifdef INSTR_ISSUE_BUFFER_BYPASS_EN
    if (bypass) begin
      for (int i = 0; i < WIDTH; i++) out_valid[i] = n_push > CNT_W'(i);
      out_data = in_data;
    end
`endif
  end

  // Storage write: untaken accepted lanes land contiguously from wr_ptr, wrapping mod DEPTH.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (push_acc && (CNT_W'(i) < n_push) && (CNT_W'(i) >= n_skip))
        mem[wr_ptr + PTR_W'(i) - PTR_W'(n_skip)] <= in_data[i*PKT_W +: PKT_W];
    end
  end

  // Pointer and occupancy update; flush discards the same-cycle push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push_acc - n_skip);
      rd_ptr <= rd_ptr + PTR_W'(n_pop - n_skip);
      count  <= count + n_push_acc - n_pop;
    end
  end

  assign full  = count > (DEPTH_C - WIDTH_C);
  assign empty = (count == '0);

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk) disable iff (reset) count <= DEPTH_C);
  a_no_overfill: assert property (@(posedge clk) disable iff (reset)
                                  !(push_acc && ((DEPTH_C - count) < WIDTH_C)));
`endif

endmodule
